// File: rtl/alu_issue_pkg.sv
// Shared constants, FSM encoding and instruction decode for the ALU issue controller.
package alu_issue_pkg;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_SLL  = 3'd5;
  localparam logic [2:0] ALU_SRL  = 3'd6;
  localparam logic [2:0] ALU_SLTU = 3'd7;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WB, ST_ERR} state_t;

  // Width-independent decode; the immediate is extended to N in the top.
  typedef struct packed {
    logic        legal;
    logic [2:0]  func;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [4:0]  shamt;
    logic        use_imm;
    logic        sext;
    logic        a_zero;
    logic [15:0] imm;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t       d;
    logic [5:0] op;
    logic [5:0] fn;
    op        = ins[31:26];
    fn        = ins[5:0];
    d         = '0;
    d.rs      = ins[25:21];
    d.rt      = ins[20:16];
    d.dest    = ins[20:16];
    d.imm     = ins[15:0];
    d.legal   = 1'b1;
    if (op == OP_RTYPE) begin
      d.dest = ins[15:11];
      case (fn)
        FN_ADD, FN_ADDU: d.func = ALU_ADD;
        FN_SUB, FN_SUBU: d.func = ALU_SUB;
        FN_AND:          d.func = ALU_AND;
        FN_OR:           d.func = ALU_OR;
        FN_XOR:          d.func = ALU_XOR;
        FN_SLTU:         d.func = ALU_SLTU;
        FN_SLL: begin d.func = ALU_SLL; d.a_zero = 1'b1; d.shamt = ins[10:6]; end
        FN_SRL: begin d.func = ALU_SRL; d.a_zero = 1'b1; d.shamt = ins[10:6]; end
        default:         d.legal = 1'b0;
      endcase
    end else begin
      d.use_imm = 1'b1;
      case (op)
        OP_ADDI, OP_ADDIU: begin d.func = ALU_ADD;  d.sext = 1'b1; end
        OP_SLTIU:          begin d.func = ALU_SLTU; d.sext = 1'b1; end
        OP_ANDI:           d.func = ALU_AND;
        OP_ORI:            d.func = ALU_OR;
        OP_XORI:           d.func = ALU_XOR;
        default:           d.legal = 1'b0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// 32 x N register file: sync clear, sync write, async reads, r0 reads as zero.
module alu_issue_regfile #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [4:0]   waddr,
  input  logic [N-1:0] wdata,
  input  logic [4:0]   raddr_a,
  input  logic [4:0]   raddr_b,
  output logic [N-1:0] rdata_a,
  output logic [N-1:0] rdata_b,
  input  logic [4:0]   dbg_addr,
  output logic [N-1:0] dbg_data
);

  logic [N-1:0] regs [32];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) regs[r] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a  = (raddr_a  == 5'd0) ? '0 : regs[raddr_a];
  assign rdata_b  = (raddr_b  == 5'd0) ? '0 : regs[raddr_b];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Serialized issue controller: accept, decode, drive registered ALU, write back.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [31:0]  instr,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_func,
  output logic [4:0]   alu_shamt,
  input  logic [N-1:0] alu_res,
  output logic         wb_valid,
  output logic [4:0]   wb_addr,
  output logic [N-1:0] wb_data,
  output logic         err_illegal,
  input  logic [4:0]   dbg_addr,
  output logic [N-1:0] dbg_data
);

  state_t       state, state_nx;
  dec_t         dec_in, dec_q;
  logic         accept;
  logic [N-1:0] rdata_a, rdata_b, imm_ext;

  assign dec_in      = decode(instr);
  assign instr_ready = (state == ST_IDLE) & rst_n;
  assign accept      = instr_valid & instr_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      dec_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) dec_q <= dec_in;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (accept) state_nx = dec_in.legal ? ST_ISSUE : ST_ERR;
      ST_ISSUE: state_nx = ST_WB;
      ST_WB:    state_nx = ST_IDLE;
      ST_ERR:   state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  assign imm_ext = dec_q.sext ? N'($signed(dec_q.imm)) : N'(dec_q.imm);

  // ALU inputs are only live in ISSUE; the ALU registers res on that cycle's edge.
  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_func  = '0;
    alu_shamt = '0;
    if (state == ST_ISSUE) begin
      alu_a     = dec_q.a_zero  ? '0      : rdata_a;
      alu_b     = dec_q.use_imm ? imm_ext : rdata_b;
      alu_func  = dec_q.func;
      alu_shamt = dec_q.shamt;
    end
  end

  assign wb_valid    = (state == ST_WB) & dec_q.legal;
  assign wb_addr     = wb_valid ? dec_q.dest : 5'd0;
  assign wb_data     = wb_valid ? alu_res : '0;
  assign err_illegal = (state == ST_ERR);

  alu_issue_regfile #(.N(N)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (wb_valid),
    .waddr    (dec_q.dest),
    .wdata    (alu_res),
    .raddr_a  (dec_q.rs),
    .raddr_b  (dec_q.rt),
    .rdata_a  (rdata_a),
    .rdata_b  (rdata_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: registered ALU model, vector table, scoreboard of expected outputs.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] alu_a, alu_b, alu_res, wb_data, dbg_data;
  logic [2:0]  alu_func;
  logic [4:0]  alu_shamt, wb_addr, dbg_addr;
  logic        wb_valid, err_illegal;

  alu_issue_ctrl #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_shamt(alu_shamt), .alu_res(alu_res), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .err_illegal(err_illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Registered ALU per the func encoding
  always @(posedge clk) begin
    case (alu_func)
      3'd0: alu_res <= alu_a + alu_b;
      3'd1: alu_res <= alu_a - alu_b;
      3'd2: alu_res <= alu_a & alu_b;
      3'd3: alu_res <= alu_a | alu_b;
      3'd4: alu_res <= alu_a ^ alu_b;
      3'd5: alu_res <= alu_b << alu_shamt;
      3'd6: alu_res <= alu_b >> alu_shamt;
      default: alu_res <= {31'd0, alu_a < alu_b};
    endcase
  end

  typedef struct { logic [31:0] ins; bit err; logic [4:0] addr; logic [31:0] data; } vec_t;
  typedef struct { bit err; logic [4:0] addr; logic [31:0] data; int due; } sb_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  vec_t cur_exp;
  sb_t  sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Accept monitor: push the expected outcome on each handshake
  always @(posedge clk) begin
    sb_t e;
    cyc++;
    if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
      e.err  = cur_exp.err;
      e.addr = cur_exp.addr;
      e.data = cur_exp.data;
      e.due  = cur_exp.err ? cyc : cyc + 1;
      sb.push_back(e);
    end
  end

  // Output monitor: pop and compare on each wb/err pulse
  always @(negedge clk) begin
    sb_t e;
    if (wb_valid === 1'b1 || err_illegal === 1'b1) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_out: wb_valid=%b err_illegal=%b wb_addr=%0d, required no output",
                 wb_valid, err_illegal, wb_addr);
      end else begin
        e = sb.pop_front();
        chk("out_err", {31'd0, err_illegal}, {31'd0, e.err});
        chk("out_wbv", {31'd0, wb_valid}, {31'd0, !e.err});
        if (!e.err) begin
          chk("wb_addr", {27'd0, wb_addr}, {27'd0, e.addr});
          chk("wb_data", wb_data, e.data);
        end
        chk("latency", cyc, e.due);
      end
    end
  end

  // Caller is #1 after a rising edge; returns #1 after the accepting edge
  task automatic send(input vec_t v);
    bit acc;
    acc = 0;
    instr = v.ins; cur_exp = v; instr_valid = 1'b1;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk); acc = instr_ready;
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    if (!acc) begin tests++; fails++; $display("FAIL accept_timeout: instr %h never accepted", v.ins); end
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) begin @(posedge clk); #1; end
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d outputs pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  vec_t        vecs [21];
  logic [31:0] dbg_exp [21];
  logic [31:0] bb_w [3];

  initial begin
    vecs[0]  = '{32'h20010005, 0, 5'd1,  32'h00000005}; // addi r1,r0,5
    vecs[1]  = '{32'h2002FFFD, 0, 5'd2,  32'hFFFFFFFD}; // addi r2,r0,-3
    vecs[2]  = '{32'h00221822, 0, 5'd3,  32'h00000008}; // sub r3,r1,r2
    vecs[3]  = '{32'h34048000, 0, 5'd4,  32'h00008000}; // ori r4,r0,0x8000
    vecs[4]  = '{32'h00042900, 0, 5'd5,  32'h00080000}; // sll r5,r4,4
    vecs[5]  = '{32'h00053502, 0, 5'd6,  32'h00000000}; // srl r6,r5,20
    vecs[6]  = '{32'h2C270006, 0, 5'd7,  32'h00000001}; // sltiu r7,r1,6
    vecs[7]  = '{32'h0041402B, 0, 5'd8,  32'h00000000}; // sltu r8,r2,r1
    vecs[8]  = '{32'h20000009, 0, 5'd0,  32'h00000009}; // addi r0,r0,9
    vecs[9]  = '{32'hFC000000, 1, 5'd0,  32'h0};        // opcode 0x3F
    vecs[10] = '{32'h0041402A, 1, 5'd0,  32'h0};        // slt
    vecs[11] = '{32'h28210001, 1, 5'd0,  32'h0};        // slti
    vecs[12] = '{32'h00000001, 1, 5'd0,  32'h0};        // unknown funct
    vecs[13] = '{32'h00414826, 0, 5'd9,  32'hFFFFFFF8}; // xor r9,r2,r1
    vecs[14] = '{32'h304AFF0F, 0, 5'd10, 32'h0000FF0D}; // andi r10,r2,0xFF0F
    vecs[15] = '{32'h242BFFFF, 0, 5'd11, 32'h00000004}; // addiu r11,r1,-1
    vecs[16] = '{32'h2C2CFFFF, 0, 5'd12, 32'h00000001}; // sltiu r12,r1,-1
    vecs[17] = '{32'h00426821, 0, 5'd13, 32'hFFFFFFFA}; // addu r13,r2,r2
    vecs[18] = '{32'h00247025, 0, 5'd14, 32'h00008005}; // or r14,r1,r4
    vecs[19] = '{32'h388FFFFF, 0, 5'd15, 32'h00007FFF}; // xori r15,r4,0xFFFF
    vecs[20] = '{32'h00018023, 0, 5'd16, 32'hFFFFFFFB}; // subu r16,r0,r1
    dbg_exp = '{32'h0, 32'h5, 32'hFFFFFFFD, 32'h8, 32'h8000, 32'h80000, 32'h0, 32'h1,
                32'h0, 32'hFFFFFFF8, 32'hFF0D, 32'h4, 32'h1, 32'hFFFFFFFA, 32'h8005,
                32'h7FFF, 32'hFFFFFFFB, 32'h1, 32'h2, 32'h3, 32'h0};
    bb_w = '{32'h20110001, 32'h20120002, 32'h20130003};

    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; dbg_addr = 5'd1; cur_exp = vecs[0];
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, instr_ready}, 32'd0);
    chk("rst_wbv",   {31'd0, wb_valid}, 32'd0);
    chk("rst_err",   {31'd0, err_illegal}, 32'd0);
    chk("rst_wbaddr", {27'd0, wb_addr}, 32'd0);
    chk("rst_wbdata", wb_data, 32'd0);
    chk("rst_alu", alu_a | alu_b | {24'd0, alu_func, alu_shamt}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_dbg_r1", dbg_data, 32'd0);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      send(vecs[i]);
      drain();
      @(negedge clk);
      chk($sformatf("ready_after_v%0d", i), {31'd0, instr_ready}, 32'd1);
      @(posedge clk); #1;
    end

    // Back-to-back with valid held: ready must go 1,0,0 repeating
    begin
      int  idx;
      bit  acc;
      vec_t v;
      idx = 0;
      v = '{bb_w[0], 0, 5'd17, 32'd1};
      instr = v.ins; cur_exp = v; instr_valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
        @(negedge clk);
        chk($sformatf("bb_ready_%0d", i), {31'd0, instr_ready}, {31'd0, (i % 3) == 0});
        acc = instr_ready;
        @(posedge clk); #1;
        if (acc) begin
          idx++;
          if (idx < 3) begin
            v = '{bb_w[idx], 0, 5'(17 + idx), 32'(idx + 1)};
            instr = v.ins; cur_exp = v;
          end else instr_valid = 1'b0;
        end
      end
      instr_valid = 1'b0;
      drain();
    end

    foreach (dbg_exp[r]) begin
      dbg_addr = 5'(r); #1;
      chk($sformatf("dbg_r%0d", r), dbg_data, dbg_exp[r]);
    end
    @(posedge clk); #1;

    // Reset while in ISSUE: the instruction is abandoned with no writeback
    send('{32'h20140007, 0, 5'd20, 32'd7});
    rst_n = 1'b0;
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    for (int r = 0; r < 32; r++) begin
      dbg_addr = 5'(r); #1;
      chk($sformatf("rst_clr_r%0d", r), dbg_data, 32'd0);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, instr_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    if (sb.size() != 0) begin tests++; fails++; $display("FAIL sb_leftover: %0d pending, required 0", sb.size()); end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
